// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared decode/execute control types for the segmented RISC-V core
package core_pkg;

   localparam int ALU_OP_WIDTH = 2;

   typedef enum logic [ALU_OP_WIDTH-1:0] {
      ADD  = 2'd0,
      SUB  = 2'd1,
      FUNC = 2'd2,
      IMM  = 2'd3
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    alu_src;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic branch;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   localparam ex_ctrl_t  BUBBLE_EX_CTRL  = '{alu_op: ADD, alu_src: 1'b0};
   localparam mem_ctrl_t BUBBLE_MEM_CTRL = '{mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0};
   localparam wb_ctrl_t  BUBBLE_WB_CTRL  = '{reg_write: 1'b0, mem_to_reg: 1'b0};

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } stage_state_t;

endpackage

// File: rtl/load_use_hazard_unit.sv
// rtl/load_use_hazard_unit.sv - load-use detect against the EX entry plus RUN/STALL tracking
module load_use_hazard_unit
   import core_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       hold_i,
   input  logic       flush_i,
   input  logic       ex_valid_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_uses_rs2_i,
   output logic       load_use_o,
   output logic       stall_o
);

   stage_state_t state_q, state_d;

   // x0 is hardwired, so a load targeting it never creates a dependency
   assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                       ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));

   assign stall_o = (load_use_o & ~flush_i) | hold_i;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (load_use_o & ~hold_i & ~flush_i) state_d = STALL;
         STALL:   if (~hold_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= RUN;
      else       state_q <= state_d;
   end

endmodule

// File: rtl/id_ex_stage_register.sv
// rtl/id_ex_stage_register.sv - ID/EX pipeline register with load-use bubbles and branch flush
// ID_EX_PERF_CNT_EN enables the bubble/flush performance counters; otherwise they read 0.
module id_ex_stage_register
   import core_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                hold_in,
   input  logic                flush_in,
   input  logic [XLEN-1:0]     pc_in,
   input  logic [XLEN-1:0]     rs1_data_in,
   input  logic [XLEN-1:0]     rs2_data_in,
   input  logic [XLEN-1:0]     imm_in,
   input  logic [4:0]          rs1_in,
   input  logic [4:0]          rs2_in,
   input  logic [4:0]          rd_in,
   input  logic [2:0]          func3_in,
   input  logic [6:0]          func7_in,
   input  logic                uses_rs2_in,
   input  logic [ALU_OP_W-1:0] alu_op_in,
   input  logic                alu_src_in,
   input  logic                mem_read_in,
   input  logic                mem_write_in,
   input  logic                reg_write_in,
   input  logic                mem_to_reg_in,
   input  logic                branch_in,
   output logic [XLEN-1:0]     pc_out,
   output logic [XLEN-1:0]     rs1_data_out,
   output logic [XLEN-1:0]     rs2_data_out,
   output logic [XLEN-1:0]     imm_out,
   output logic [4:0]          rs1_out,
   output logic [4:0]          rs2_out,
   output logic [4:0]          rd_out,
   output logic [2:0]          func3_out,
   output logic [6:0]          func7_out,
   output logic                uses_rs2_out,
   output logic [ALU_OP_W-1:0] alu_op_out,
   output logic                alu_src_out,
   output logic                mem_read_out,
   output logic                mem_write_out,
   output logic                reg_write_out,
   output logic                mem_to_reg_out,
   output logic                branch_out,
   output logic                valid_out,
   output logic                stall_if_id_out,
   output logic [31:0]         bubble_count_out,
   output logic [31:0]         flush_count_out
);

   logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic [2:0]      func3_q;
   logic [6:0]      func7_q;
   logic            uses_rs2_q, valid_q, valid_d;
   ex_ctrl_t        ex_q, ex_d;
   mem_ctrl_t       mem_q, mem_d;
   wb_ctrl_t        wb_q, wb_d;
   logic            load_use;

   load_use_hazard_unit u_hazard (
      .clk_i         (CLK),
      .rst_i         (RST),
      .hold_i        (hold_in),
      .flush_i       (flush_in),
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (mem_q.mem_read),
      .ex_rd_i       (rd_q),
      .id_rs1_i      (rs1_in),
      .id_rs2_i      (rs2_in),
      .id_uses_rs2_i (uses_rs2_in),
      .load_use_o    (load_use),
      .stall_o       (stall_if_id_out)
   );

   // Only control is squashed on a bubble; datapath fields pass through as don't-care
   always_comb begin
      ex_d    = BUBBLE_EX_CTRL;
      mem_d   = BUBBLE_MEM_CTRL;
      wb_d    = BUBBLE_WB_CTRL;
      valid_d = 1'b0;
      if (!(flush_in || load_use)) begin
         ex_d.alu_op     = alu_op_t'(alu_op_in);
         ex_d.alu_src    = alu_src_in;
         mem_d.mem_read  = mem_read_in;
         mem_d.mem_write = mem_write_in;
         mem_d.branch    = branch_in;
         wb_d.reg_write  = reg_write_in;
         wb_d.mem_to_reg = mem_to_reg_in;
         valid_d         = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         func3_q    <= '0;
         func7_q    <= '0;
         uses_rs2_q <= 1'b0;
         ex_q       <= BUBBLE_EX_CTRL;
         mem_q      <= BUBBLE_MEM_CTRL;
         wb_q       <= BUBBLE_WB_CTRL;
         valid_q    <= 1'b0;
      end else if (!hold_in) begin
         pc_q       <= pc_in;
         rs1_data_q <= rs1_data_in;
         rs2_data_q <= rs2_data_in;
         imm_q      <= imm_in;
         rs1_q      <= rs1_in;
         rs2_q      <= rs2_in;
         rd_q       <= rd_in;
         func3_q    <= func3_in;
         func7_q    <= func7_in;
         uses_rs2_q <= uses_rs2_in;
         ex_q       <= ex_d;
         mem_q      <= mem_d;
         wb_q       <= wb_d;
         valid_q    <= valid_d;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, flush_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else if (!hold_in) begin
         if (flush_in)      flush_cnt_q  <= flush_cnt_q + 32'd1;
         else if (load_use) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign bubble_count_out = bubble_cnt_q;
   assign flush_count_out  = flush_cnt_q;
`else
   assign bubble_count_out = '0;
   assign flush_count_out  = '0;
`endif

   assign pc_out         = pc_q;
   assign rs1_data_out   = rs1_data_q;
   assign rs2_data_out   = rs2_data_q;
   assign imm_out        = imm_q;
   assign rs1_out        = rs1_q;
   assign rs2_out        = rs2_q;
   assign rd_out         = rd_q;
   assign func3_out      = func3_q;
   assign func7_out      = func7_q;
   assign uses_rs2_out   = uses_rs2_q;
   assign alu_op_out     = ex_q.alu_op;
   assign alu_src_out    = ex_q.alu_src;
   assign mem_read_out   = mem_q.mem_read;
   assign mem_write_out  = mem_q.mem_write;
   assign branch_out     = mem_q.branch;
   assign reg_write_out  = wb_q.reg_write;
   assign mem_to_reg_out = wb_q.mem_to_reg;
   assign valid_out      = valid_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb/tb_id_ex_stage_register.sv - randomized self-checking bench for id_ex_stage_register
module tb_id_ex_stage_register;

   logic        CLK = 1'b0;
   logic        RST, hold_in, flush_in;
   logic [31:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;
   logic [2:0]  func3_in;
   logic [6:0]  func7_in;
   logic        uses_rs2_in;
   logic [1:0]  alu_op_in;
   logic        alu_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, branch_in;

   logic [31:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic [2:0]  func3_out;
   logic [6:0]  func7_out;
   logic        uses_rs2_out;
   logic [1:0]  alu_op_out;
   logic        alu_src_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out, branch_out;
   logic        valid_out, stall_if_id_out;
   logic [31:0] bubble_count_out, flush_count_out;

   int total = 0;
   int bad   = 0;

   // Reference EX entry: what the stage should hold after each edge
   logic [31:0] e_pc, e_rs1d, e_rs2d, e_imm;
   logic [4:0]  e_rs1, e_rs2, e_rd;
   logic [2:0]  e_f3;
   logic [6:0]  e_f7;
   logic        e_uses2;
   logic [1:0]  e_aluop;
   logic        e_alusrc, e_mr, e_mw, e_rw, e_m2r, e_br, e_valid;
   logic [31:0] e_bub, e_fl;

   id_ex_stage_register dut (
      .CLK(CLK), .RST(RST), .hold_in(hold_in), .flush_in(flush_in),
      .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .func3_in(func3_in), .func7_in(func7_in),
      .uses_rs2_in(uses_rs2_in), .alu_op_in(alu_op_in), .alu_src_in(alu_src_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
      .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
      .pc_out(pc_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .func3_out(func3_out),
      .func7_out(func7_out), .uses_rs2_out(uses_rs2_out), .alu_op_out(alu_op_out),
      .alu_src_out(alu_src_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .branch_out(branch_out),
      .valid_out(valid_out), .stall_if_id_out(stall_if_id_out),
      .bubble_count_out(bubble_count_out), .flush_count_out(flush_count_out)
   );

   always #5 CLK = ~CLK;

   function automatic logic [162:0] act_vec();
      return {pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out, rs2_out, rd_out,
              func3_out, func7_out, uses_rs2_out, alu_op_out, alu_src_out, mem_read_out,
              mem_write_out, reg_write_out, mem_to_reg_out, branch_out, valid_out};
   endfunction

   function automatic logic [162:0] exp_vec();
      return {e_pc, e_rs1d, e_rs2d, e_imm, e_rs1, e_rs2, e_rd, e_f3, e_f7, e_uses2,
              e_aluop, e_alusrc, e_mr, e_mw, e_rw, e_m2r, e_br, e_valid};
   endfunction

   function automatic logic model_load_use();
      return e_valid && e_mr && (e_rd != 5'd0) &&
             ((e_rd == rs1_in) || (uses_rs2_in && (e_rd == rs2_in)));
   endfunction

   function automatic logic exp_stall();
      return (model_load_use() && !flush_in) || hold_in;
   endfunction

   function automatic logic [31:0] exp_bub();
`ifdef ID_EX_PERF_CNT_EN
      return e_bub;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_fl();
`ifdef ID_EX_PERF_CNT_EN
      return e_fl;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_step();
      logic lu;
      lu = model_load_use();
      if (RST) begin
         {e_pc, e_rs1d, e_rs2d, e_imm, e_rs1, e_rs2, e_rd, e_f3, e_f7, e_uses2} = '0;
         {e_aluop, e_alusrc, e_mr, e_mw, e_rw, e_m2r, e_br, e_valid} = '0;
         e_bub = 0;
         e_fl  = 0;
      end else if (!hold_in) begin
         e_pc = pc_in;  e_rs1d = rs1_data_in;  e_rs2d = rs2_data_in;  e_imm = imm_in;
         e_rs1 = rs1_in;  e_rs2 = rs2_in;  e_rd = rd_in;  e_f3 = func3_in;  e_f7 = func7_in;
         e_uses2 = uses_rs2_in;
         if (flush_in || lu) begin
            {e_aluop, e_alusrc, e_mr, e_mw, e_rw, e_m2r, e_br, e_valid} = '0;
            if (flush_in) e_fl  = e_fl + 1;
            else          e_bub = e_bub + 1;
         end else begin
            e_aluop = alu_op_in;  e_alusrc = alu_src_in;  e_mr = mem_read_in;
            e_mw = mem_write_in;  e_rw = reg_write_in;  e_m2r = mem_to_reg_in;
            e_br = branch_in;  e_valid = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_inputs();
      pc_in = $urandom;  rs1_data_in = $urandom;  rs2_data_in = $urandom;  imm_in = $urandom;
      rs1_in = 5'($urandom);  rs2_in = 5'($urandom);  rd_in = 5'($urandom);
      func3_in = 3'($urandom);  func7_in = 7'($urandom);  uses_rs2_in = 1'($urandom);
      alu_op_in = 2'($urandom);  alu_src_in = 1'($urandom);  mem_read_in = 1'($urandom);
      mem_write_in = 1'($urandom);  reg_write_in = 1'($urandom);
      mem_to_reg_in = 1'($urandom);  branch_in = 1'($urandom);
   endtask

   // Leaves a non-load in EX so the next directed step starts hazard-free
   task automatic prime();
      rand_inputs();
      rs1_in = 0;  rs2_in = 0;  mem_read_in = 0;  hold_in = 0;  flush_in = 0;
      cycle();
   endtask

   task automatic test_reset();
      RST = 1;  hold_in = 0;  flush_in = 0;
      rand_inputs();
      cycle();
      rand_inputs();
      cycle();
      total++;
      if (act_vec() !== 163'd0) begin
         bad++;  $display("FAIL reset_outputs got=%h want=0", act_vec());
      end
      total++;
      if (bubble_count_out !== 32'd0 || flush_count_out !== 32'd0) begin
         bad++;  $display("FAIL reset_counters got=%0d/%0d want=0/0", bubble_count_out, flush_count_out);
      end
      total++;
      if (stall_if_id_out !== 1'b0) begin
         bad++;  $display("FAIL reset_stall got=%b want=0", stall_if_id_out);
      end
      RST = 0;
   endtask

   task automatic test_capture();
      prime();
      rand_inputs();
      pc_in = 32'h100;  func3_in = 3'b000;  func7_in = 7'h20;  alu_op_in = 2'd2;
      rs1_in = 0;  rs2_in = 0;
      cycle();
      total++;
      if (act_vec() !== exp_vec()) begin
         bad++;  $display("FAIL capture_vec got=%h want=%h", act_vec(), exp_vec());
      end
      total++;
      if (pc_out !== 32'h100 || func7_out !== 7'h20 || alu_op_out !== 2'd2 || valid_out !== 1'b1) begin
         bad++;  $display("FAIL capture_fields got pc=%h f7=%h op=%0d v=%b want pc=100 f7=20 op=2 v=1",
                          pc_out, func7_out, alu_op_out, valid_out);
      end
   endtask

   task automatic test_load_use();
      prime();
      rand_inputs();
      rd_in = 5;  mem_read_in = 1;  reg_write_in = 1;  rs1_in = 0;  rs2_in = 0;
      cycle();
      rand_inputs();
      rs1_in = 5;  rs2_in = 0;  mem_read_in = 0;  reg_write_in = 1;
      #1;
      total++;
      if (stall_if_id_out !== 1'b1) begin
         bad++;  $display("FAIL load_use_stall got=%b want=1", stall_if_id_out);
      end
      cycle();
      total++;
      if (act_vec() !== exp_vec() || reg_write_out !== 1'b0 || valid_out !== 1'b0) begin
         bad++;  $display("FAIL load_use_bubble got=%h want=%h", act_vec(), exp_vec());
      end
      total++;
      if (bubble_count_out !== exp_bub()) begin
         bad++;  $display("FAIL load_use_bubble_count got=%0d want=%0d", bubble_count_out, exp_bub());
      end
      #1;
      total++;
      if (stall_if_id_out !== 1'b0) begin
         bad++;  $display("FAIL load_use_stall_release got=%b want=0", stall_if_id_out);
      end
      cycle();
      total++;
      if (act_vec() !== exp_vec() || valid_out !== 1'b1 || reg_write_out !== 1'b1) begin
         bad++;  $display("FAIL load_use_recapture got=%h want=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_no_hazard();
      prime();
      rand_inputs();
      rd_in = 0;  mem_read_in = 1;  rs1_in = 0;  rs2_in = 0;
      cycle();
      rand_inputs();
      rs1_in = 0;  rs2_in = 0;  uses_rs2_in = 1;  rd_in = 7;  mem_read_in = 1;
      #1;
      total++;
      if (stall_if_id_out !== 1'b0) begin
         bad++;  $display("FAIL rd0_no_stall got=%b want=0", stall_if_id_out);
      end
      cycle();
      rs1_in = 3;  rs2_in = 7;  uses_rs2_in = 0;  mem_read_in = 0;
      #1;
      total++;
      if (stall_if_id_out !== 1'b0) begin
         bad++;  $display("FAIL rs2_unused_no_stall got=%b want=0", stall_if_id_out);
      end
      uses_rs2_in = 1;
      #1;
      total++;
      if (stall_if_id_out !== 1'b1) begin
         bad++;  $display("FAIL rs2_used_stall got=%b want=1", stall_if_id_out);
      end
      uses_rs2_in = 0;
      cycle();
      total++;
      if (act_vec() !== exp_vec() || valid_out !== 1'b1) begin
         bad++;  $display("FAIL no_hazard_capture got=%h want=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_flush();
      logic [31:0] bub0;
      prime();
      rand_inputs();
      rd_in = 9;  mem_read_in = 1;  rs1_in = 0;  rs2_in = 0;
      cycle();
      bub0 = bubble_count_out;
      rand_inputs();
      rs1_in = 9;  flush_in = 1;
      #1;
      total++;
      if (stall_if_id_out !== 1'b0) begin
         bad++;  $display("FAIL flush_no_stall got=%b want=0", stall_if_id_out);
      end
      cycle();
      flush_in = 0;
      total++;
      if (act_vec() !== exp_vec() || valid_out !== 1'b0) begin
         bad++;  $display("FAIL flush_bubble got=%h want=%h", act_vec(), exp_vec());
      end
      total++;
      if (flush_count_out !== exp_fl() || bubble_count_out !== bub0) begin
         bad++;  $display("FAIL flush_counts got=%0d/%0d want=%0d/%0d",
                          flush_count_out, bubble_count_out, exp_fl(), bub0);
      end
   endtask

   task automatic test_hold();
      logic [162:0] frozen;
      prime();
      rand_inputs();
      rd_in = 6;  mem_read_in = 1;  rs1_in = 0;  rs2_in = 0;
      cycle();
      rand_inputs();
      rs1_in = 6;  mem_read_in = 0;
      cycle();
      frozen = exp_vec();
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         hold_in = 1;
         flush_in = 1'($urandom);
         #1;
         total++;
         if (stall_if_id_out !== 1'b1) begin
            bad++;  $display("FAIL hold_stall[%0d] got=%b want=1", i, stall_if_id_out);
         end
         cycle();
         total++;
         if (act_vec() !== frozen || bubble_count_out !== exp_bub() || flush_count_out !== exp_fl()) begin
            bad++;  $display("FAIL hold_frozen[%0d] got=%h cnt=%0d/%0d want=%h cnt=%0d/%0d", i,
                             act_vec(), bubble_count_out, flush_count_out, frozen, exp_bub(), exp_fl());
         end
      end
      hold_in = 0;  flush_in = 0;
      rand_inputs();
      rs1_in = 6;  mem_read_in = 0;
      #1;
      total++;
      if (stall_if_id_out !== 1'b0) begin
         bad++;  $display("FAIL hold_release_stall got=%b want=0", stall_if_id_out);
      end
      cycle();
      total++;
      if (act_vec() !== exp_vec() || valid_out !== 1'b1 || bubble_count_out !== exp_bub()) begin
         bad++;  $display("FAIL hold_release_capture got=%h want=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         rs1_in = 5'($urandom_range(0, 3));
         rs2_in = 5'($urandom_range(0, 3));
         rd_in  = 5'($urandom_range(0, 3));
         hold_in  = ($urandom_range(0, 7) == 0);
         flush_in = ($urandom_range(0, 7) == 0);
         #1;
         total++;
         if (stall_if_id_out !== exp_stall()) begin
            bad++;  $display("FAIL rand_stall[%0d] got=%b want=%b", i, stall_if_id_out, exp_stall());
         end
         cycle();
         total++;
         if (act_vec() !== exp_vec()) begin
            bad++;  $display("FAIL rand_vec[%0d] got=%h want=%h", i, act_vec(), exp_vec());
         end
         total++;
         if (bubble_count_out !== exp_bub() || flush_count_out !== exp_fl()) begin
            bad++;  $display("FAIL rand_counts[%0d] got=%0d/%0d want=%0d/%0d", i,
                             bubble_count_out, flush_count_out, exp_bub(), exp_fl());
         end
      end
      hold_in = 0;  flush_in = 0;
   endtask

   initial begin
      RST = 1;  hold_in = 0;  flush_in = 0;
      rand_inputs();
      test_reset();
      test_capture();
      test_load_use();
      test_no_hazard();
      test_flush();
      test_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- ID/EX pipeline register of the segmented RISC-V core; the producing end of the decode-to-execute interface.
- Captures decode-stage operands, instruction fields and control, and presents them to EX consumers: ALU controller (func7, func3, alu_op), ALU, and the MEM/WB control chain.
- Embeds load-use hazard detection, bubble insertion and branch flush.

Parameters:
- XLEN, 32, datapath width.
- ALU_OP_W, 2, alu_op control width.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous active-high reset.
- hold_in  in  1  external freeze (memory wait); all EX state held.
- flush_in  in  1  branch taken in EX; next captured entry is a bubble.
- pc_in  in  XLEN  ID PC.
- rs1_data_in, rs2_data_in, imm_in  in  XLEN  register-file outputs and immediate.
- rs1_in, rs2_in, rd_in  in  5  instruction[19:15], [24:20], [11:7].
- func3_in  in  3  instruction[14:12].
- func7_in  in  7  instruction[31:25].
- uses_rs2_in  in  1  decoded instruction reads rs2.
- alu_op_in  in  ALU_OP_W; alu_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, branch_in  in  1 each.
- All of the above except hold/flush mirrored as *_out, registered.
- valid_out  out  1  EX entry is a real instruction.
- stall_if_id_out  out  1  hold PC and IF/ID this cycle.
- bubble_count_out, flush_count_out  out  32  performance counters.

Behaviour:
- Reset (RST=1 at posedge): all *_out and valid_out 0, counters 0. alu_op_out=0, which encodes ADD.
- Latency: 1 cycle, ID inputs to *_out.
- Hazard (combinational):
  - load_use = valid_out & mem_read_out & (rd_out!=0) & ((rd_out==rs1_in) | (uses_rs2_in & rd_out==rs2_in)).
  - stall_if_id_out = (load_use & ~flush_in) | hold_in.
- Per-edge priority: RST > hold_in > flush_in > load_use > normal capture.
  - hold_in: every register keeps its value, counters included.
  - flush_in: bubble captured; flush_count +1.
  - load_use: bubble captured; bubble_count +1.
  - normal: all inputs captured; valid_out=1.
- Bubble definition:
  - valid_out, reg_write_out, mem_read_out, mem_write_out, branch_out, mem_to_reg_out, alu_src_out = 0; alu_op_out = 0.
  - Datapath fields (pc, data, imm, rs/rd, func) captured as normal, so they are don't-care for checkers.
- FSM, 2 states:
  - RUN → STALL on load_use & ~hold_in & ~flush_in.
  - STALL → RUN unconditionally on the next non-hold edge. The bubble clears mem_read_out, so the stall lasts exactly 1 cycle.
  - hold_in in STALL keeps STALL.
- Simultaneous flush_in & load_use: flush wins; no stall asserted; only flush_count increments.
- rd_out==0 never triggers a hazard.
- Counters wrap at 2^32-1 → 0.

Optional Feature:
- ID_EX_PERF_CNT_EN defined: bubble_count_out and flush_count_out count as specified above.
- Not defined: counter registers are removed; both ports are tied to 0; ports remain in the interface.

Decomposition:
- Shared package core_pkg:
  - alu_op_t enum (ADD=0, SUB=1, FUNC=2, IMM=3), width ALU_OP_W.
  - ex_ctrl_t struct (alu_op, alu_src), mem_ctrl_t struct (mem_read, mem_write, branch), wb_ctrl_t struct (reg_write, mem_to_reg).
  - BUBBLE_CTRL constants for the three control structs.
  - stage_state_t enum {RUN, STALL}.
- One sub-module: load_use_hazard_unit (combinational detect plus the RUN/STALL FSM), instantiated inside.

Test Plan:
- Reset: RST=1 for 2 cycles with random inputs → all outputs 0, state RUN.
- Capture: pc_in=0x100, func3_in=3'b000, func7_in=7'h20, alu_op_in=FUNC → next cycle identical *_out, valid_out=1.
- Load-use: EX holds lw with rd=5 (mem_read_out=1); ID drives add with rs1=5 →
  - stall_if_id_out=1 for exactly 1 cycle;
  - next entry is a bubble (reg_write_out=0);
  - bubble_count=1;
  - add captured the cycle after.
- rd_out=0 load with rs1_in=0, and rs2 match with uses_rs2_in=0 → no stall.
- flush_in=1 coincident with a load-use match → bubble, no stall, flush_count=1, bubble_count=0.
- hold_in=1 for 3 cycles during STALL → outputs and counters frozen; single bubble after release; PERF macro undefined → counters read 0 throughout.
